// File: rtl/vending_coin_feeder_if.sv
// vending_coin_feeder_if
//   Board-level coin/sell/change bundle between the customer-side coin feeder
//   and the vending machine. It also carries the wallet load/buy controls and
//   the feeder status.
//
//   Signal roles:
//     load, load_half, load_one : wallet load strobe and the coin counts to load
//     buy                       : purchase request
//     sell, change              : drink dispensed, plus the change returned
//     coin                      : coin strobe toward the machine
//     busy, done, fail          : feeder status (done/fail are one-cycle pulses)
//     wallet_half, wallet_one   : current wallet contents
//
//   Handshake semantics: there is no ready back-pressure on this bus.
//     - A non-zero 'coin' is a one-cycle transfer. The machine must take it
//       in that cycle, and 'coin' is always 00 on the following cycle.
//     - 'sell' is a one-cycle valid that qualifies 'change'. 'change' is only
//       looked at in a cycle where 'sell' is high.
//     - 'load' and 'buy' are level requests. They are sampled only while the
//       feeder is idle (busy low), and 'load' wins when both are high.
//
//   Modports:
//     master : the coin feeder
//     slave  : the machine or test side that faces it
interface vending_coin_feeder_if #(
  parameter int CNT_W = 8
);
  logic             load;
  logic [CNT_W-1:0] load_half;
  logic [CNT_W-1:0] load_one;
  logic             buy;
  logic             sell;
  logic [1:0]       change;
  logic [1:0]       coin;
  logic             busy;
  logic             done;
  logic             fail;
  logic [CNT_W-1:0] wallet_half;
  logic [CNT_W-1:0] wallet_one;

  modport master (
    input  load, load_half, load_one, buy, sell, change,
    output coin, busy, done, fail, wallet_half, wallet_one
  );

  modport slave (
    output load, load_half, load_one, buy, sell, change,
    input  coin, busy, done, fail, wallet_half, wallet_one
  );
endinterface

// File: rtl/vending_coin_feeder.sv
// vending_coin_feeder
//   Customer-side initiator for the vending machine. It keeps a wallet of
//   0.5-yuan and 1-yuan coins. On a buy request it inserts coins one at a time,
//   with a one-cycle gap between coins, until the price is covered. It then
//   waits for 'sell', banks any change into the wallet, and pulses done or fail.
//
//   Ports:
//     clk         : clock; all logic runs on the rising edge
//     rstn        : asynchronous, active-low reset
//     io_bus      : vending_coin_feeder_if.master (load/buy/sell/change in,
//                   coin/busy/done/fail/wallet out)
//     o_dbg_state : current FSM state, for checkers
//                   IDLE=0 PAY=1 GAP=2 WAIT=3 DONE=4 ERR=5
module vending_coin_feeder #(
  parameter int PRICE_HALF = 3,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  vending_coin_feeder_if.master io_bus,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PAY  = 3'd1,
    S_GAP  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [3:0]       PRICE_P   = 4'(PRICE_HALF);
  localparam logic [CNT_W+1:0] PRICE_W   = (CNT_W+2)'(PRICE_HALF);
  localparam logic [7:0]       TIMEOUT_T = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_coin;
  logic [3:0]       r_paid;
  logic [7:0]       r_to;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_one;

  logic [CNT_W+1:0] w_funds;
  logic             w_funds_ok;
  logic [3:0]       w_paid_base;
  logic [3:0]       w_remaining;
  logic [1:0]       w_coin_sel;
  logic [7:0]       w_to_inc;

  // Coin choice for the coin being registered on this edge.
  // A purchase starts from paid = 0, so when leaving IDLE the stale paid value
  // is ignored.
  always_comb begin
    w_funds     = {1'b0, r_one, 1'b0} + {2'b00, r_half};
    w_funds_ok  = (w_funds >= PRICE_W);
    w_paid_base = (r_state == S_IDLE) ? 4'd0 : r_paid;
    w_remaining = PRICE_P - w_paid_base;
    w_to_inc    = r_to + 8'd1;
    if (w_remaining >= 4'd2 && r_one != '0)
      w_coin_sel = 2'b10;
    else if (r_half != '0)
      w_coin_sel = 2'b01;
    else
      w_coin_sel = 2'b10;  // overpay with a 1-yuan coin; the funds check guarantees one exists
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM: next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!io_bus.load && io_bus.buy)
          w_next = w_funds_ok ? S_PAY : S_ERR;
      end
      S_PAY: begin
        if (io_bus.sell)            w_next = S_ERR;  // sold before full payment
        else if (r_paid >= PRICE_P) w_next = S_WAIT;
        else                        w_next = S_GAP;
      end
      S_GAP: begin
        w_next = io_bus.sell ? S_ERR : S_PAY;
      end
      S_WAIT: begin
        // A sell in the last allowed cycle wins over the timeout.
        if (io_bus.sell)
          w_next = (io_bus.change == 2'b11) ? S_ERR : S_DONE;
        else if (w_to_inc == TIMEOUT_T)
          w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs. These are decoded from registered state only.
  always_comb begin
    io_bus.coin        = r_coin;
    io_bus.busy        = (r_state != S_IDLE);
    io_bus.done        = (r_state == S_DONE);
    io_bus.fail        = (r_state == S_ERR);
    io_bus.wallet_half = r_half;
    io_bus.wallet_one  = r_one;
    o_dbg_state        = r_state;
  end

  // Datapath: coin register, paid counter, wallet counters, timeout counter.
  // The coin is registered on the same edge that enters PAY, so it is visible
  // exactly for the PAY cycle. The wallet decrement happens on that same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_coin <= 2'b00;
      r_paid <= 4'd0;
      r_to   <= 8'd0;
      r_half <= '0;
      r_one  <= '0;
    end else begin
      r_coin <= 2'b00;

      if (r_state == S_IDLE && io_bus.load) begin
        r_half <= io_bus.load_half;
        r_one  <= io_bus.load_one;
      end

      if (w_next == S_PAY) begin
        r_coin <= w_coin_sel;
        if (w_coin_sel == 2'b10) begin
          r_paid <= w_paid_base + 4'd2;
          r_one  <= r_one - CNT_ONE;
        end else begin
          r_paid <= w_paid_base + 4'd1;
          r_half <= r_half - CNT_ONE;
        end
      end

      if (r_state == S_WAIT) begin
        r_to <= w_to_inc;
        if (io_bus.sell) begin
          if (io_bus.change == 2'b01 && r_half != CNT_MAX) r_half <= r_half + CNT_ONE;
          if (io_bus.change == 2'b10 && r_one  != CNT_MAX) r_one  <= r_one + CNT_ONE;
        end
      end else begin
        r_to <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_vending_coin_feeder.sv
// tb_vending_coin_feeder
//   Bench for vending_coin_feeder. A purchase-level reference model derives,
//   for each cycle after 'buy', the expected {coin, done, fail, busy}. It also
//   tracks the wallet contents.
module tb_vending_coin_feeder;

  localparam int PRICE_HALF = 3;
  localparam int CNT_W      = 8;
  localparam int TIMEOUT    = 8;
  localparam int CNT_MAXV   = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rstn;
  logic [2:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vending_coin_feeder_if #(.CNT_W(CNT_W)) bus ();

  vending_coin_feeder #(
    .PRICE_HALF(PRICE_HALF),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .io_bus     (bus.master),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_cmp;
  int         n_err;
  int         m_half;      // model wallet
  int         m_one;
  logic [4:0] exp_q[$];    // {coin[1:0], done, fail, busy} per cycle after buy
  logic [4:0] obs_q[$];

  // ---------------- reference model ----------------
  // Works at purchase level: build the coin list from the payment rules,
  // decide how the purchase ends, then lay the result out on a cycle grid.
  // Coins occupy the odd cycles, gaps the even ones, and WAIT starts at
  // cycle 2n.
  task automatic model_purchase(input int sell_at, input logic [1:0] chg);
    int         paid;
    int         n;
    int         term;
    int         limit;
    int         h;
    int         o;
    bit         ok;
    bit         is_done;
    logic [1:0] coins[$];
    logic [1:0] c;
    paid = 0;
    h = m_half;
    o = m_one;
    ok = (2 * m_one + m_half >= PRICE_HALF);
    while (ok && paid < PRICE_HALF && coins.size() < 8) begin
      if (PRICE_HALF - paid >= 2 && o > 0) begin coins.push_back(2'b10); o--; paid += 2; end
      else if (h > 0)                      begin coins.push_back(2'b01); h--; paid += 1; end
      else                                 begin coins.push_back(2'b10); o--; paid += 2; end
    end
    n = coins.size();
    limit = 1 << 20;
    is_done = 1'b0;
    if (!ok) begin
      term = 1;
      limit = 0;
    end else if (sell_at >= 1 && sell_at < 2 * n) begin
      term = sell_at + 1;       // sold before full payment
      limit = sell_at;
    end else if (sell_at >= 2 * n && sell_at < 2 * n + TIMEOUT) begin
      term = sell_at + 1;
      is_done = (chg != 2'b11);
    end else begin
      term = 2 * n + TIMEOUT;   // timed out in WAIT
    end
    exp_q.delete();
    for (int k = 1; k <= term + 1; k++) begin
      c = 2'b00;
      if (k % 2 == 1 && (k - 1) / 2 < n && k <= limit) c = coins[(k - 1) / 2];
      exp_q.push_back({c, (k == term) && is_done, (k == term) && !is_done, k <= term});
    end
    for (int i = 0; i < n; i++) begin
      if (2 * i + 1 <= limit) begin
        if (coins[i] == 2'b10) m_one--;
        else                   m_half--;
      end
    end
    if (is_done && chg == 2'b01) m_half = (m_half < CNT_MAXV) ? m_half + 1 : CNT_MAXV;
    if (is_done && chg == 2'b10) m_one  = (m_one  < CNT_MAXV) ? m_one + 1  : CNT_MAXV;
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_reset();
    rstn = 1'b0;
    bus.load = 1'b0;
    bus.load_half = '0;
    bus.load_one = '0;
    bus.buy = 1'b0;
    bus.sell = 1'b0;
    bus.change = 2'b00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    m_half = 0;
    m_one = 0;
  endtask

  task automatic load_wallet(input int h, input int o);
    bus.load = 1'b1;
    bus.load_half = CNT_W'(h);
    bus.load_one = CNT_W'(o);
    @(negedge clk);
    bus.load = 1'b0;
    m_half = h;
    m_one = o;
  endtask

  // Raises buy for one edge, then records ncyc cycles of outputs. 'sell' is
  // high during cycle sell_at (cycle 1 is the first cycle after the buy edge).
  task automatic drive_purchase(input int sell_at, input logic [1:0] chg, input int ncyc);
    obs_q.delete();
    bus.buy = 1'b1;
    bus.sell = 1'b0;
    bus.change = chg;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      bus.buy = 1'b0;
      obs_q.push_back({bus.coin, bus.done, bus.fail, bus.busy});
      bus.sell = (k == sell_at) && (k < ncyc);
    end
    bus.sell = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++;
    if ({bus.coin, bus.done, bus.fail, bus.busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 00000", {bus.coin, bus.done, bus.fail, bus.busy});
    end
    n_cmp++;
    if (bus.wallet_half !== '0 || bus.wallet_one !== '0) begin
      n_err++;
      $display("FAIL reset_wallet: got half=%0d one=%0d want 0/0", bus.wallet_half, bus.wallet_one);
    end
  endtask

  task automatic test_purchases();
    int dir_h[9] = '{0, 3, 1, 0, 0, 0, 1, 0, 0};
    int dir_o[9] = '{2, 0, 0, 2, 2, 2, 1, 3, 2};
    int dir_s[9] = '{4, 6, 0, 0, 2, 4, 11, 4, 3};
    logic [1:0] dir_c[9] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
    int h;
    int o;
    int s;
    logic [1:0] c;
    for (int t = 0; t < 25; t++) begin
      if (t < 9) begin
        h = dir_h[t]; o = dir_o[t]; s = dir_s[t]; c = dir_c[t];
      end else begin
        h = $urandom_range(0, 3);
        o = $urandom_range(0, 3);
        s = $urandom_range(0, 16);
        c = 2'($urandom_range(0, 3));
      end
      load_wallet(h, o);
      model_purchase(s, c);
      drive_purchase(s, c, exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_err++;
          $display("FAIL purchase%0d cyc%0d {coin,done,fail,busy}: got %b want %b (h=%0d o=%0d sell_at=%0d chg=%b)",
                   t, k + 1, obs_q[k], exp_q[k], h, o, s, c);
        end
      end
      n_cmp++;
      if (bus.wallet_half !== CNT_W'(m_half) || bus.wallet_one !== CNT_W'(m_one)) begin
        n_err++;
        $display("FAIL purchase%0d wallet: got half=%0d one=%0d want half=%0d one=%0d",
                 t, bus.wallet_half, bus.wallet_one, m_half, m_one);
      end
    end
  endtask

  task automatic test_back_to_back();
    load_wallet(4, 4);
    for (int p = 0; p < 3; p++) begin
      // Sell in the first WAIT cycle. The next buy is raised in the first
      // IDLE cycle after done.
      model_purchase(4, 2'b00);
      drive_purchase(4, 2'b00, exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_err++;
          $display("FAIL back_to_back%0d cyc%0d: got %b want %b", p, k + 1, obs_q[k], exp_q[k]);
        end
      end
    end
    n_cmp++;
    if (bus.wallet_half !== CNT_W'(m_half) || bus.wallet_one !== CNT_W'(m_one)) begin
      n_err++;
      $display("FAIL back_to_back wallet: got half=%0d one=%0d want half=%0d one=%0d",
               bus.wallet_half, bus.wallet_one, m_half, m_one);
    end
  endtask

  task automatic test_load_buy_same_cycle();
    bus.load = 1'b1;
    bus.buy = 1'b1;
    bus.load_half = CNT_W'(2);
    bus.load_one = CNT_W'(2);
    @(negedge clk);
    bus.load = 1'b0;
    bus.buy = 1'b0;
    m_half = 2;
    m_one = 2;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({bus.coin, bus.busy} !== 3'b000) begin
        n_err++;
        $display("FAIL load_buy_idle cyc%0d: got coin=%b busy=%b want 00/0", k, bus.coin, bus.busy);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bus.wallet_half !== CNT_W'(2) || bus.wallet_one !== CNT_W'(2)) begin
      n_err++;
      $display("FAIL load_buy_wallet: got half=%0d one=%0d want 2/2", bus.wallet_half, bus.wallet_one);
    end
  endtask

  task automatic test_reset_mid_pay();
    load_wallet(0, 2);
    bus.buy = 1'b1;
    @(negedge clk);
    bus.buy = 1'b0;
    n_cmp++;
    if (bus.coin !== 2'b10) begin
      n_err++;
      $display("FAIL rst_mid_first_coin: got %b want 10", bus.coin);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (bus.coin !== 2'b00 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_async: got coin=%b busy=%b want 00/0", bus.coin, bus.busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    m_half = 0;
    m_one = 0;
    n_cmp++;
    if ({bus.coin, bus.done, bus.fail, bus.busy} !== 5'b0 ||
        bus.wallet_half !== '0 || bus.wallet_one !== '0) begin
      n_err++;
      $display("FAIL rst_mid_release: got %b half=%0d one=%0d want 00000 0/0",
               {bus.coin, bus.done, bus.fail, bus.busy}, bus.wallet_half, bus.wallet_one);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    do_reset();
    test_reset();
    test_purchases();
    test_back_to_back();
    test_load_buy_same_cycle();
    test_reset_mid_pay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vending_coin_feeder.md
# vending_coin_feeder

Customer-side initiator for the vending machine coin interface: holds a wallet of 0.5-yuan and 1-yuan coins, and on a buy request inserts coins one at a time on `coin[1:0]` until the drink price is reached. It then waits for `sell`, banks any returned `change` into the wallet and reports done or fail. It sits opposite the vending machine FSM on the same board-level coin/sell/change interface, and serves as the drive agent in system-level runs.

## Interface
- `PRICE_HALF`, 3: drink price in 0.5-yuan units (3 = 1.5 yuan); legal range 1..6.
- `CNT_W`, 8: width of each wallet coin counter.
- `TIMEOUT`, 8: maximum cycles spent in WAIT for `sell` before failing; legal range 1..255.
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `load`  in  1  wallet load strobe; honoured only in IDLE.
- `load_half`  in  CNT_W  0.5-yuan coin count to load.
- `load_one`  in  CNT_W  1-yuan coin count to load.
- `buy`  in  1  purchase request; honoured only in IDLE, and only when `load` is low.
- `sell`  in  1  drink-dispensed indication from the machine.
- `change`  in  2  change from the machine: 00 none, 01 = 0.5 yuan, 10 = 1 yuan, 11 invalid.
- `coin`  out  2  coin to the machine (registered): 00 none, 01 = 0.5 yuan, 10 = 1 yuan.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: purchase completed.
- `fail`  out  1  one-cycle pulse: purchase rejected or aborted.
- `wallet_half`  out  CNT_W  current 0.5-yuan coin count.
- `wallet_one`  out  CNT_W  current 1-yuan coin count.

## Operation
- States: IDLE, PAY, GAP, WAIT, DONE, ERR.
- Reset values: state IDLE; `coin` 00; `busy`, `done`, `fail` 0; both wallet counters 0; paid counter 0; timeout counter 0.
- IDLE:
  - `load`=1 copies `load_half` and `load_one` into the wallet. `buy` is ignored on that cycle.
  - `buy`=1 checks funds: 2·`wallet_one` + `wallet_half` ≥ `PRICE_HALF`, evaluated at CNT_W+2 bits with no overflow.
  - Sufficient funds: clear paid and go to PAY. Insufficient funds: go to ERR; no coin is issued.
  - `sell` and `change` are ignored in IDLE.
- PAY drives exactly one coin for one cycle, chosen in this priority order (remaining = `PRICE_HALF` − paid):
  - remaining ≥ 2 and `wallet_one` > 0: `coin`=10, decrement `wallet_one`, add 2 to paid.
  - else `wallet_half` > 0: `coin`=01, decrement `wallet_half`, add 1 to paid.
  - else: `coin`=10 (overpay), decrement `wallet_one`, add 2 to paid.
  - Next state: if paid ≥ `PRICE_HALF`, go to WAIT; otherwise go to GAP.
- GAP: `coin`=00 for one cycle, then return to PAY. Coins are therefore never on consecutive cycles.
- WAIT: `coin`=00 and the timeout counter increments each cycle.
  - `sell`=1 with `change` 01 or 10: add one coin of that value to the wallet (saturating at 2^CNT_W−1), then go to DONE.
  - `sell`=1 with `change`=11: no wallet update; go to ERR.
  - Timeout counter reaches `TIMEOUT` with no `sell`: go to ERR. Coins already inserted are not refunded.
- `sell`=1 observed in PAY or GAP (machine sold before full payment): go to ERR immediately and stop inserting coins.
- DONE: `done`=1 for one cycle, then IDLE. ERR: `fail`=1 for one cycle, then IDLE.
- Paid counter is 4 bits; its maximum value is `PRICE_HALF`+1.
- Reset mid-purchase: every register returns to its reset value, and `coin` goes to 00 asynchronously.

## Timing
- `buy` is sampled on edge N. On edge N+1 the state is PAY; `coin` carries the first coin during cycle N+1..N+2.
- Wallet counters update on the same edge that registers the coin.
- Each coin is high for exactly one cycle. With PRICE_HALF=3, a one-yuan + half-yuan payment looks like this: `coin` = 10, 00, 01, then WAIT.
- `sell` is accepted from the first WAIT cycle onward. The machine may assert `sell` in the cycle right after the final coin.
- `done`/`fail` rise one edge after the deciding event. `busy` falls on the same edge that `done`/`fail` falls.
- A new `buy` is accepted on the first IDLE cycle after `done`/`fail`; the minimum spacing from `done` to the next first coin is 2 cycles.
- Insufficient-funds path: `buy` at edge N, `fail` during N+1..N+2, and no coin is driven.

## Test plan
- Load half=0, one=2; buy; machine sells with `change`=01 in the cycle after the second coin. Required: `coin` sequence 10,00,10; `done` pulse; wallet ends at half=1, one=0.
- Load half=3, one=0; buy. Required: `coin` sequence 01,00,01,00,01; `sell` with `change`=00 gives `done`; wallet ends at half=0, one=0.
- Load half=1, one=0; buy. Required: `fail` pulse 1 cycle after `buy`; `coin` stays 00; wallet unchanged.
- Load half=0, one=2; buy; machine never asserts `sell`. Required: `fail` exactly `TIMEOUT` cycles after entering WAIT; wallet stays half=0, one=0.
- Assert `sell` during the first GAP. Required: ERR, `fail` pulse, no further coins. Separately: `change`=11 in WAIT gives `fail` with no wallet increment.
- Assert `rstn` low during PAY. Required: `coin`=00 immediately; on release, all outputs are 0 and state is IDLE. `load` and `buy` raised together in IDLE: the wallet loads and the purchase does not start.
